dec_grant_sched: RTL and testbench

Round-robin scheduler that shares one 3-to-8 decoded select bus among 8 requesters. Picks one requester, holds its grant while it keeps requesting (bounded by a hold limit), inserts a guard gap, then re-arbitrates. Drives the 3-bit index that feeds the existing decoder datapath and also provides the decoded one-hot grant directly. Sits between requesting agents and the shared decoded resource.

---
 rtl/dec_grant_sched.sv | 113 +++++++++++
 tb/tb_dec_grant_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_grant_sched.sv
// Round-robin scheduler for one shared 3-to-8 decoded select bus across 8 requesters.
// A grant is held while its requester keeps requesting, up to MAX_HOLD cycles, then a guard gap follows.
module dec_grant_sched #(
   parameter int MAX_HOLD   = 16,
   parameter int GAP_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] req,
   output logic [2:0] gnt_idx,
   output logic       gnt_valid,
   output logic [7:0] gnt,
   output logic       preempt,
   output logic [1:0] dbg_state
);

   // gnt_valid has no ready: the winner owns the bus for every cycle gnt_valid=1,
   // and the grant ends only when req[gnt_idx] drops or the hold limit is reached.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] idx_d;
   logic       valid_d;
   logic       preempt_d;
   logic [2:0] ptr_q, ptr_d;
   logic [7:0] hold_q, hold_d;
   logic [3:0] gap_q, gap_d;
   logic       win_found;
   logic [2:0] win_idx;

   // Descending scan so the candidate closest to ptr (k=0) is assigned last and wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr_q;
      for (int k = 7; k >= 0; k--) begin
         if (req[ptr_q + 3'(k)]) begin
            win_found = 1'b1;
            win_idx   = ptr_q + 3'(k);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = gnt_idx;
      valid_d   = gnt_valid;
      preempt_d = 1'b0;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      gap_d     = gap_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               idx_d   = win_idx;
               valid_d = 1'b1;
               hold_d  = 8'd1;
               state_d = GRANT;
            end
         end
         GRANT: begin
            // A release on the limit edge takes priority, so preempt only flags a still-requesting winner.
            if (!req[gnt_idx] || hold_q == 8'(MAX_HOLD)) begin
               preempt_d = req[gnt_idx];
               valid_d   = 1'b0;
               ptr_d     = gnt_idx + 3'd1;
               gap_d     = 4'd1;
               state_d   = GAP;
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end
         GAP: begin
            if (gap_q == 4'(GAP_CYCLES)) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         gnt_idx   <= 3'd0;
         gnt_valid <= 1'b0;
         preempt   <= 1'b0;
         ptr_q     <= 3'd0;
         hold_q    <= 8'd0;
         gap_q     <= 4'd0;
      end else begin
         state_q   <= state_d;
         gnt_idx   <= idx_d;
         gnt_valid <= valid_d;
         preempt   <= preempt_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         gap_q     <= gap_d;
      end
   end

   assign gnt       = gnt_valid ? (8'b1 << gnt_idx) : 8'h00;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_dec_grant_sched.sv
// Bench for dec_grant_sched: directed scenarios with literal checks plus random requests,
// all outputs compared every cycle against a behavioural model through an expected queue.
module tb_dec_grant_sched;

   localparam int MAX_HOLD   = 4;
   localparam int GAP_CYCLES = 1;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] req   = 8'h00;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic [7:0] gnt;
   logic       preempt;
   logic [1:0] dbg_state;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [12:0] exp_q[$];

   bit m_valid, m_pre;
   int m_idx, m_ptr, m_held, m_gap_left;

   logic [2:0] rec_idx[8];
   int         rec_n;

   dec_grant_sched #(.MAX_HOLD(MAX_HOLD), .GAP_CYCLES(GAP_CYCLES)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .gnt       (gnt),
      .preempt   (preempt),
      .dbg_state (dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog actual=still running required=finished");
      $fatal(1, "watchdog");
   end

   // behavioural model: grant bookkeeping with plain integers
   function automatic void model_reset();
      m_valid = 0; m_pre = 0; m_idx = 0; m_ptr = 0; m_held = 0; m_gap_left = 0;
   endfunction

   function automatic void model_end(bit p);
      m_valid    = 0;
      m_pre      = p;
      m_ptr      = (m_idx + 1) % 8;
      m_gap_left = GAP_CYCLES;
   endfunction

   function automatic void model_step(logic [7:0] r);
      m_pre = 0;
      if (m_valid) begin
         if (!r[m_idx]) model_end(0);
         else if (m_held == MAX_HOLD) model_end(1);
         else m_held++;
      end else if (m_gap_left > 0) begin
         m_gap_left--;
      end else if (r != 8'h00) begin
         for (int k = 0; k < 8; k++) begin
            if (r[(m_ptr + k) % 8]) begin
               m_idx = (m_ptr + k) % 8;
               break;
            end
         end
         m_valid = 1;
         m_held  = 1;
      end
   endfunction

   function automatic logic [12:0] model_word();
      logic [7:0] g;
      g = m_valid ? 8'(1 << m_idx) : 8'h00;
      return {m_valid, 3'(m_idx), g, m_pre};
   endfunction

   always @(negedge reset) begin
      model_reset();
      exp_q.delete();
   end

   always @(posedge clk) begin
      if (!reset) model_reset();
      else model_step(req);
      exp_q.push_back(model_word());
   end

   // scoreboard: one comparison per cycle
   always @(negedge clk) begin : cmp
      logic [12:0] e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {gnt_valid, gnt_idx, gnt, preempt};
         tests_run++;
         if (a !== e) begin
            tests_failed++;
            $display("FAIL outputs t=%0t actual valid=%0b idx=%0d gnt=%h pre=%0b required valid=%0b idx=%0d gnt=%h pre=%0b",
                     $time, a[12], a[11:9], a[8:1], a[0], e[12], e[11:9], e[8:1], e[0]);
         end
      end
   end

   // driver tasks
   task automatic check_lit(input string name, input logic [7:0] act, input logic [7:0] expv);
      tests_run++;
      if (act !== expv) begin
         tests_failed++;
         $display("FAIL %s actual=%h required=%h", name, act, expv);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      req = 8'h00;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1 reset = 1'b1;
   endtask

   task automatic wait_grant(input string name);
      int i;
      for (i = 0; i < 20 && !gnt_valid; i++) tick();
      check_lit({name, "_grant_seen"}, {7'd0, gnt_valid}, 8'h01);
   endtask

   // Serves grants for pattern pat; each winner drops its bit after hold_len valid cycles.
   task automatic run_grants(input logic [7:0] pat, input int hold_len, input int n);
      int   cnt;
      logic prev_v;
      rec_n  = 0;
      cnt    = 0;
      prev_v = 1'b0;
      req    = pat;
      for (int c = 0; c < 80 && rec_n < n; c++) begin
         tick();
         if (gnt_valid && !prev_v) begin
            rec_idx[rec_n] = gnt_idx;
            rec_n++;
            cnt = 0;
         end
         if (gnt_valid) cnt++;
         prev_v = gnt_valid;
         req = (gnt_valid && cnt >= hold_len) ? (pat & ~(8'h01 << gnt_idx)) : pat;
      end
      check_lit("grant_count", 8'(rec_n), 8'(n));
   endtask

   initial begin
      int         exp_order[4];
      int         len;
      int         hold_left;
      logic [7:0] r;

      // reset behaviour
      req = 8'hFF;
      repeat (2) tick();
      check_lit("rst_gnt", gnt, 8'h00);
      check_lit("rst_valid", {7'd0, gnt_valid}, 8'h00);
      check_lit("rst_idx", {5'd0, gnt_idx}, 8'h00);
      reset = 1'b1;
      tick();
      check_lit("first_gnt", gnt, 8'h01);
      check_lit("first_idx", {5'd0, gnt_idx}, 8'h00);
      idle(4);

      // round-robin rotation from ptr=0
      do_reset();
      tick();
      exp_order = '{0, 2, 5, 0};
      run_grants(8'h25, 3, 4);
      for (int i = 0; i < 4; i++)
         check_lit($sformatf("rot_%0d", i), {5'd0, rec_idx[i]}, 8'(exp_order[i]));
      idle(4);

      // wrap-around after a winner at idx 7
      run_grants(8'h80, 1, 1);
      check_lit("wrap_pre7", {5'd0, rec_idx[0]}, 8'd7);
      idle(4);
      run_grants(8'h81, 1, 2);
      check_lit("wrap_first", {5'd0, rec_idx[0]}, 8'd0);
      check_lit("wrap_second", {5'd0, rec_idx[1]}, 8'd7);
      idle(4);

      // hold limit with a requester that never lets go
      req = 8'h08;
      wait_grant("hold");
      len = 0;
      for (int i = 0; i < 20 && gnt_valid; i++) begin
         len++;
         tick();
      end
      check_lit("hold_len", 8'(len), 8'(MAX_HOLD));
      check_lit("hold_preempt", {7'd0, preempt}, 8'h01);
      check_lit("hold_gap_gnt", gnt, 8'h00);
      tick();
      check_lit("hold_preempt_clear", {7'd0, preempt}, 8'h00);
      tick();
      check_lit("hold_regrant", gnt, 8'h08);
      idle(4);

      // release and limit on the same edge
      req = 8'h08;
      wait_grant("simul");
      repeat (MAX_HOLD - 1) tick();
      req = 8'h00;
      tick();
      check_lit("simul_preempt", {7'd0, preempt}, 8'h00);
      check_lit("simul_valid", {7'd0, gnt_valid}, 8'h00);
      req = 8'h19;
      wait_grant("simul_next");
      check_lit("simul_ptr_idx", {5'd0, gnt_idx}, 8'd4);
      idle(4);

      // asynchronous reset in the middle of a grant
      req = 8'h20;
      wait_grant("midrst");
      check_lit("midrst_before", gnt, 8'h20);
      reset = 1'b0;
      #1;
      check_lit("midrst_gnt", gnt, 8'h00);
      check_lit("midrst_valid", {7'd0, gnt_valid}, 8'h00);
      req = 8'h24;
      #1 reset = 1'b1;
      tick();
      check_lit("midrst_winner", gnt, 8'h04);
      idle(4);

      // random traffic
      hold_left = 0;
      r = 8'h00;
      for (int c = 0; c < 500; c++) begin
         if (hold_left == 0) begin
            case ($urandom_range(0, 3))
               0:       r = 8'h00;
               1:       r = 8'(1 << $urandom_range(0, 7));
               default: r = 8'($urandom_range(0, 255));
            endcase
            hold_left = $urandom_range(1, 12);
         end
         hold_left--;
         req = r;
         if ($urandom_range(0, 149) == 0) do_reset();
         tick();
      end
      idle(3);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
